// File: rtl/sa_inst_receiver.sv
// sa_inst_receiver
//
// Instruction fetch/dispatch front end for the systolic-array controller. The
// block strobes `flag` to fetch one instruction word from the host. It decodes
// the opcode and hands legal, non-IDLE operations to the execution unit with a
// one-cycle `exec_start` pulse. It then waits for `exec_done` before fetching
// again. IDLE and illegal opcodes do not dispatch; an illegal opcode raises the
// sticky `err` flag.
//
// Instruction layout (MSB first): {opcode, addra, addrb}
//   0 IDLE             3 AXI_TO_WB           6 MAT_MUL
//   1 AXI_TO_UB        4 UB_TO_DATA_FIFO     7 MAT_MUL_ACC
//   2 UB_TO_AXI        5 UB_TO_WEIGHT_FIFO   8 ACC_TO_UB
//   9 and above are illegal.
//
// State sequence: WAIT -> FETCH -> (DISPATCH -> BUSY ->) GAP -> FETCH ...
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   synchronous active-low reset
//   instruction  in   instruction word, sampled on the edge ending the flag cycle
//   flag         out  fetch strobe, high for exactly one cycle per fetch
//   idle_flag    out  low while an operation is dispatched or executing
//   exec_start   out  one-cycle dispatch pulse
//   exec_opcode  out  latched opcode, stable from dispatch to the next dispatch
//   exec_addra   out  latched ADDRA field
//   exec_addrb   out  latched ADDRB field
//   exec_done    in   completion from the execution unit, honoured only in BUSY
//   err          out  sticky error: illegal opcode or watchdog timeout
//
// Build option
//   SA_INST_WDT_EN  When defined, a watchdog counts BUSY cycles. It forces BUSY -> GAP
//                   and sets err after WDT_CYCLES cycles without exec_done.
//                   When undefined, BUSY waits indefinitely.

module sa_inst_receiver #(
  parameter int unsigned OPCODE_BITS = 4,
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned INST_BITS   = OPCODE_BITS + 2 * ADDR_BITS,
  parameter int unsigned WDT_CYCLES  = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INST_BITS-1:0]   instruction,
  output logic                   flag,
  output logic                   idle_flag,
  output logic                   exec_start,
  output logic [OPCODE_BITS-1:0] exec_opcode,
  output logic [ADDR_BITS-1:0]   exec_addra,
  output logic [ADDR_BITS-1:0]   exec_addrb,
  input  logic                   exec_done,
  output logic                   err
);

  localparam logic [OPCODE_BITS-1:0] OpIdle      = '0;
  localparam logic [OPCODE_BITS-1:0] OpLastLegal = OPCODE_BITS'(8);

  typedef enum logic [2:0] {
    StWait     = 3'd0,
    StFetch    = 3'd1,
    StDispatch = 3'd2,
    StBusy     = 3'd3,
    StGap      = 3'd4
  } state_e;

  state_e state_q;

  // Instruction field extraction and opcode classification.
  logic [OPCODE_BITS-1:0] fetch_op;
  logic [ADDR_BITS-1:0]   fetch_addra;
  logic [ADDR_BITS-1:0]   fetch_addrb;
  logic                   op_exec;
  logic                   op_illegal;

  assign fetch_op    = instruction[INST_BITS-1 -: OPCODE_BITS];
  assign fetch_addra = instruction[2*ADDR_BITS-1 -: ADDR_BITS];
  assign fetch_addrb = instruction[ADDR_BITS-1:0];

  always_comb begin
    op_exec    = 1'b0;
    op_illegal = 1'b0;
    if (fetch_op > OpLastLegal) begin
      op_illegal = 1'b1;
    end else if (fetch_op != OpIdle) begin
      op_exec = 1'b1;
    end
  end

`ifdef SA_INST_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

  logic [WdtW-1:0] wdt_cnt_q;
`endif

  // A single registered FSM. All outputs are registered alongside the state,
  // so each output reflects the state entered on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StWait;
      flag        <= 1'b0;
      idle_flag   <= 1'b1;
      exec_start  <= 1'b0;
      exec_opcode <= '0;
      exec_addra  <= '0;
      exec_addrb  <= '0;
      err         <= 1'b0;
`ifdef SA_INST_WDT_EN
      wdt_cnt_q   <= '0;
`endif
    end else begin
      // Strobes default low and are raised only on entry to their state.
      flag       <= 1'b0;
      exec_start <= 1'b0;

      unique case (state_q)
        StWait: begin
          state_q   <= StFetch;
          flag      <= 1'b1;
          idle_flag <= 1'b1;
        end

        StFetch: begin
          if (op_exec) begin
            state_q     <= StDispatch;
            exec_start  <= 1'b1;
            idle_flag   <= 1'b0;
            exec_opcode <= fetch_op;
            exec_addra  <= fetch_addra;
            exec_addrb  <= fetch_addrb;
`ifdef SA_INST_WDT_EN
            wdt_cnt_q   <= '0;
`endif
          end else begin
            // IDLE and illegal opcodes leave the exec_* fields untouched.
            state_q <= StGap;
            if (op_illegal) begin
              err <= 1'b1;
            end
          end
        end

        // exec_done is deliberately not looked at here; completion counts only
        // once the execution unit has seen exec_start.
        StDispatch: begin
          state_q <= StBusy;
        end

        StBusy: begin
          if (exec_done) begin
            state_q   <= StGap;
            idle_flag <= 1'b1;
          end
`ifdef SA_INST_WDT_EN
          else if (wdt_cnt_q == WdtLast) begin
            // The counter started at zero on the first BUSY cycle. Hitting
            // WdtLast here means WDT_CYCLES cycles have passed in BUSY.
            state_q   <= StGap;
            idle_flag <= 1'b1;
            err       <= 1'b1;
          end else begin
            wdt_cnt_q <= wdt_cnt_q + WdtW'(1);
          end
`endif
        end

        StGap: begin
          state_q <= StFetch;
          flag    <= 1'b1;
        end

        default: begin
          state_q   <= StWait;
          idle_flag <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_inst_receiver.sv
// Directed testbench for sa_inst_receiver. The main body is a table of fetched
// instructions with hand-computed timing and output expectations. Hand-written
// sequences cover the reset, early-done, mid-operation reset and watchdog
// corner cases.

module tb_sa_inst_receiver;

  localparam int unsigned OB = 4;
  localparam int unsigned AB = 16;
  localparam int unsigned IB = OB + 2 * AB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IB-1:0] instruction;
  logic          flag;
  logic          idle_flag;
  logic          exec_start;
  logic [OB-1:0] exec_opcode;
  logic [AB-1:0] exec_addra;
  logic [AB-1:0] exec_addrb;
  logic          exec_done;
  logic          err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sa_inst_receiver #(
    .OPCODE_BITS(OB),
    .ADDR_BITS  (AB),
    .INST_BITS  (IB),
    .WDT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instruction(instruction),
    .flag       (flag),
    .idle_flag  (idle_flag),
    .exec_start (exec_start),
    .exec_opcode(exec_opcode),
    .exec_addra (exec_addra),
    .exec_addrb (exec_addrb),
    .exec_done  (exec_done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [OB-1:0] op;
    logic [AB-1:0] a;
    logic [AB-1:0] b;
    int            busy;      // exec_done asserted this many cycles after exec_start
    bit            exp_start;
    logic [OB-1:0] exp_op;    // exec_* expected from fetch until the next flag
    logic [AB-1:0] exp_a;
    logic [AB-1:0] exp_b;
    bit            exp_err;
    int            period;    // flag-to-flag distance in cycles
    int            idle_low;  // cycles with idle_flag = 0
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  vec_t v;
  int   cyc;
  int   starts;
  int   idle_low;
  int   done_at;
  int   flag_at;
  int   hold_bad;
  int   bad;
  int   n;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            op     a         b         busy st  exp_op exp_a     exp_b     err per idle
    vecs[0] = '{4'd0,  16'h0000, 16'h0000, 0,  0, 4'd0, 16'h0000, 16'h0000, 0, 2,  0};
    vecs[1] = '{4'd0,  16'h1111, 16'h2222, 0,  0, 4'd0, 16'h0000, 16'h0000, 0, 2,  0};
    vecs[2] = '{4'd1,  16'd5,    16'd20,   10, 1, 4'd1, 16'd5,    16'd20,   0, 13, 11};
    vecs[3] = '{4'd2,  16'h1234, 16'hABCD, 1,  1, 4'd2, 16'h1234, 16'hABCD, 0, 4,  2};
    vecs[4] = '{4'd8,  16'hFFFF, 16'h0001, 3,  1, 4'd8, 16'hFFFF, 16'h0001, 0, 6,  4};
    vecs[5] = '{4'd12, 16'h0AAA, 16'h0BBB, 0,  0, 4'd8, 16'hFFFF, 16'h0001, 1, 2,  0};
    vecs[6] = '{4'd6,  16'h0100, 16'h0200, 2,  1, 4'd6, 16'h0100, 16'h0200, 1, 5,  3};
    vecs[7] = '{4'd9,  16'h7777, 16'h8888, 0,  0, 4'd6, 16'h0100, 16'h0200, 1, 2,  0};
    vecs[8] = '{4'd15, 16'h5555, 16'h6666, 0,  0, 4'd6, 16'h0100, 16'h0200, 1, 2,  0};
    vecs[9] = '{4'd4,  16'h0003, 16'h0004, 5,  1, 4'd4, 16'h0003, 16'h0004, 1, 8,  6};

    // ---- Reset and release ----
    reset_n     = 1'b0;
    instruction = '0;
    exec_done   = 1'b0;
    step();
    step();
    check("rst_flag",        flag,        0);
    check("rst_idle_flag",   idle_flag,   1);
    check("rst_exec_start",  exec_start,  0);
    check("rst_exec_opcode", exec_opcode, 0);
    check("rst_exec_addra",  exec_addra,  0);
    check("rst_exec_addrb",  exec_addrb,  0);
    check("rst_err",         err,         0);
    reset_n = 1'b1;
    check("release_cycle1_flag", flag, 0);
    step();
    check("release_cycle2_flag", flag, 1);

    // ---- Table-driven fetches ----
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      check($sformatf("v%0d_flag_at_fetch", i), flag, 1);
      instruction = {v.op, v.a, v.b};
      step();
      cyc = 1;
      // Junk while flag is low must not be picked up.
      instruction = {4'd6, 16'hDEAD, 16'hBEEF};
      check($sformatf("v%0d_exec_start_latency", i), exec_start, v.exp_start);
      starts   = 0;
      idle_low = 0;
      done_at  = -1;
      flag_at  = -1;
      hold_bad = 0;
      while (cyc <= 60) begin
        if (flag === 1'b1) begin
          flag_at = cyc;
          break;
        end
        if (exec_start === 1'b1) starts++;
        if (idle_flag !== 1'b1) idle_low++;
        if (exec_opcode !== v.exp_op || exec_addra !== v.exp_a || exec_addrb !== v.exp_b)
          hold_bad++;
        if (v.exp_start && cyc == 1 + v.busy) begin
          exec_done = 1'b1;
          done_at   = cyc;
        end
        step();
        exec_done = 1'b0;
        cyc++;
      end
      check($sformatf("v%0d_flag_period", i),   flag_at,  v.period);
      check($sformatf("v%0d_start_count", i),   starts,   v.exp_start ? 1 : 0);
      check($sformatf("v%0d_idle_low", i),      idle_low, v.idle_low);
      check($sformatf("v%0d_exec_fields", i),   hold_bad, 0);
      check($sformatf("v%0d_err", i),           err,      v.exp_err);
      if (v.exp_start)
        check($sformatf("v%0d_done_to_flag", i), flag_at - done_at, 2);
    end

    // ---- exec_done during DISPATCH is ignored ----
    instruction = {4'd7, 16'h00AA, 16'h00BB};
    exec_done   = 1'b1;
    step();
    check("early_done_exec_start", exec_start, 1);
    step();
    exec_done = 1'b0;
    check("early_done_still_busy", idle_flag, 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (idle_flag !== 1'b0 || flag !== 1'b0) bad++;
    end
    check("early_done_busy_hold", bad, 0);
    check("early_done_opcode", exec_opcode, 7);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check("early_done_gap_idle", idle_flag, 1);
    check("early_done_gap_flag", flag, 0);
    step();
    check("early_done_next_flag", flag, 1);

    // ---- Reset while BUSY, then a stale exec_done ----
    instruction = {4'd3, 16'h0042, 16'h0099};
    step();
    check("busy_rst_dispatch", exec_start, 1);
    instruction = '0;
    step();
    step();
    check("busy_rst_in_busy", idle_flag, 0);
    reset_n = 1'b0;
    step();
    check("busy_rst_flag",        flag,        0);
    check("busy_rst_idle_flag",   idle_flag,   1);
    check("busy_rst_exec_start",  exec_start,  0);
    check("busy_rst_exec_opcode", exec_opcode, 0);
    check("busy_rst_exec_addra",  exec_addra,  0);
    check("busy_rst_exec_addrb",  exec_addrb,  0);
    check("busy_rst_err",         err,         0);
    reset_n   = 1'b1;
    exec_done = 1'b1;
    step();
    check("busy_rst_release_flag", flag, 1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (exec_start !== 1'b0 || idle_flag !== 1'b1) bad++;
    end
    check("stale_done_ignored", bad, 0);
    exec_done = 1'b0;
    n = 0;
    while (flag !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("stale_done_flag_reached", flag, 1);

`ifdef SA_INST_WDT_EN
    // ---- Watchdog: no exec_done, WDT_CYCLES = 16 ----
    instruction = {4'd6, 16'h0001, 16'h0002};
    step();
    check("wdt_dispatch", exec_start, 1);
    step();
    check("wdt_busy_entry", idle_flag, 0);
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (idle_flag !== 1'b0 || err !== 1'b0) bad++;
    end
    check("wdt_busy_hold", bad, 0);
    step();
    check("wdt_err",       err,       1);
    check("wdt_idle_flag", idle_flag, 1);
    check("wdt_gap_flag",  flag,      0);
    step();
    check("wdt_next_flag", flag, 1);
`else
    // ---- No watchdog: BUSY waits as long as exec_done is absent ----
    instruction = {4'd5, 16'h0010, 16'h0020};
    step();
    check("nowdt_dispatch", exec_start, 1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (idle_flag !== 1'b0 || err !== 1'b0 || flag !== 1'b0) bad++;
    end
    check("nowdt_busy_hold", bad, 0);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check("nowdt_gap_idle", idle_flag, 1);
    step();
    check("nowdt_next_flag", flag, 1);
    check("nowdt_err", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
